// File: rtl/debug_uart_pkg.sv
// Shared constants and types for the debug UART snapshot serializer.
// Frame layout constants live here so the parent and the byte transmitter agree.
package debug_uart_pkg;

    localparam logic [7:0] SYNC0         = 8'hCA;
    localparam logic [7:0] SYNC1         = 8'hFE;
    localparam int         FRAME_BYTES   = 25;
    localparam int         IDLE_BITS     = 10;
    localparam int         BITS_PER_BYTE = 10;

    typedef logic [4:0] byte_idx_t;

    typedef enum logic {
        ST_SEND = 1'b0,
        ST_GAP  = 1'b1
    } frame_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter, LSB first, DIV clocks per bit.
// ready rises in the final stop-bit cycle so a byte offered then follows with no gap.
module uart_tx_byte
    import debug_uart_pkg::*;
#(
    parameter int DIV = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int TW = $clog2(DIV);

    logic          busy;
    logic [TW-1:0] timer;
    logic [3:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;
    logic          last_bit;

    assign bit_end  = (timer == TW'(DIV - 1));
    assign last_bit = (bit_idx == 4'(BITS_PER_BYTE - 1));
    assign ready    = !busy || (bit_end && last_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else if (valid && ready) begin
            busy    <= 1'b1;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= data;
            tx      <= 1'b0;
        end else if (busy) begin
            if (!bit_end) begin
                timer <= timer + TW'(1);
            end else if (last_bit) begin
                busy    <= 1'b0;
                timer   <= '0;
                bit_idx <= '0;
            end else begin
                // shifting in ones makes the tenth bit the stop bit for free
                timer   <= '0;
                bit_idx <= bit_idx + 4'd1;
                tx      <= shreg[0];
                shreg   <= {1'b1, shreg[7:1]};
            end
        end
    end

endmodule

// File: rtl/debug_uart_serializer.sv
// Snapshots bring-up state once per frame and streams it as 25 gapless 8N1 bytes,
// followed by a fixed idle gap, forever.
//
//   state   | meaning
//   ST_SEND | offering byte byte_idx of the current frame to the transmitter
//   ST_GAP  | line idle between frames; gap_cnt counts down to the next frame
module debug_uart_serializer
    import debug_uart_pkg::*;
#(
    parameter int W   = 16,
    parameter int DIV = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                tx_o,
    input  logic signed [W-1:0] adc0,
    input  logic signed [W-1:0] adc1,
    input  logic signed [W-1:0] adc2,
    input  logic signed [W-1:0] adc3,
    input  logic [7:0]          eeprom_mfg,
    input  logic [7:0]          eeprom_dev,
    input  logic [31:0]         eeprom_serial,
    input  logic [7:0]          jack,
    input  logic [7:0]          touch0,
    input  logic [7:0]          touch1,
    input  logic [7:0]          touch2,
    input  logic [7:0]          touch3,
    input  logic [7:0]          touch4,
    input  logic [7:0]          touch5,
    input  logic [7:0]          touch6,
    input  logic [7:0]          touch7
);

    // gap counting starts when the last byte is accepted, so it also covers that byte's 10 bits
    localparam int GAP_CYCLES = (IDLE_BITS + BITS_PER_BYTE) * DIV;
    localparam int GW         = $clog2(GAP_CYCLES);

    logic [W-1:0]  adc_raw   [4];
    logic [15:0]   adc_cvt   [4];
    logic [7:0]    touch_raw [8];

    frame_state_t  state;
    byte_idx_t     byte_idx;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    snap_mfg;
    logic [7:0]    snap_dev;
    logic [31:0]   snap_serial;
    logic [7:0]    snap_jack;
    logic [7:0]    snap_touch [8];
    logic [15:0]   snap_adc   [4];

    logic [7:0]    tx_data;
    logic [2:0]    touch_sel;
    logic [2:0]    adc_sel;
    logic          valid;
    logic          ready;
    logic          accept;

    assign adc_raw[0]   = adc0;
    assign adc_raw[1]   = adc1;
    assign adc_raw[2]   = adc2;
    assign adc_raw[3]   = adc3;
    assign touch_raw[0] = touch0;
    assign touch_raw[1] = touch1;
    assign touch_raw[2] = touch2;
    assign touch_raw[3] = touch3;
    assign touch_raw[4] = touch4;
    assign touch_raw[5] = touch5;
    assign touch_raw[6] = touch6;
    assign touch_raw[7] = touch7;

    for (genvar i = 0; i < 4; i++) begin : g_adc
        if (W < 16) begin : g_ext
            assign adc_cvt[i] = {{(16 - W){adc_raw[i][W-1]}}, adc_raw[i]};
        end else if (W > 16) begin : g_trunc
            assign adc_cvt[i] = adc_raw[i][W-1 -: 16];
        end else begin : g_pass
            assign adc_cvt[i] = adc_raw[i];
        end
    end

    always_comb begin
        tx_data   = 8'h00;
        touch_sel = 3'(byte_idx - 5'd9);
        adc_sel   = 3'(byte_idx - 5'd17);
        case (byte_idx) inside
            5'd0:          tx_data = SYNC0;
            5'd1:          tx_data = SYNC1;
            5'd2:          tx_data = snap_mfg;
            5'd3:          tx_data = snap_dev;
            5'd4:          tx_data = snap_serial[31:24];
            5'd5:          tx_data = snap_serial[23:16];
            5'd6:          tx_data = snap_serial[15:8];
            5'd7:          tx_data = snap_serial[7:0];
            5'd8:          tx_data = snap_jack;
            [5'd9:5'd16]:  tx_data = snap_touch[touch_sel];
            [5'd17:5'd24]: tx_data = adc_sel[0] ? snap_adc[adc_sel[2:1]][7:0]
                                                : snap_adc[adc_sel[2:1]][15:8];
            default:       tx_data = 8'h00;
        endcase
    end

    assign valid  = (state == ST_SEND) || (gap_cnt == '0);
    assign accept = valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_SEND;
            byte_idx    <= '0;
            gap_cnt     <= '0;
            snap_mfg    <= '0;
            snap_dev    <= '0;
            snap_serial <= '0;
            snap_jack   <= '0;
            snap_touch  <= '{default: '0};
            snap_adc    <= '{default: '0};
        end else begin
            // the sync bytes never read the snapshot, so capturing on byte 0 keeps the frame coherent
            if (accept && byte_idx == '0) begin
                snap_mfg    <= eeprom_mfg;
                snap_dev    <= eeprom_dev;
                snap_serial <= eeprom_serial;
                snap_jack   <= jack;
                snap_touch  <= touch_raw;
                snap_adc    <= adc_cvt;
            end
            case (state)
                ST_SEND: begin
                    if (accept) begin
                        if (byte_idx == byte_idx_t'(FRAME_BYTES - 1)) begin
                            state    <= ST_GAP;
                            byte_idx <= '0;
                            gap_cnt  <= GW'(GAP_CYCLES - 1);
                        end else begin
                            byte_idx <= byte_idx + 5'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end else if (accept) begin
                        state    <= ST_SEND;
                        byte_idx <= byte_idx_t'(1);
                    end
                end
                default: state <= ST_SEND;
            endcase
        end
    end

    uart_tx_byte #(.DIV(DIV)) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (tx_data),
        .valid (valid),
        .ready (ready),
        .tx    (tx_o)
    );

endmodule

// File: tb/tb_debug_uart_serializer.sv
// Directed bench for the debug UART serializer: decodes the serial line and
// compares against hand-computed frames, timing and reset behaviour.
module tb_debug_uart_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        tx_a;
    logic        tx_b;
    logic [15:0] adc0, adc1, adc2, adc3;
    logic [7:0]  mfg, dev, jack;
    logic [31:0] serial;
    logic [7:0]  touch [8];

    logic [11:0] b_adc0;
    logic [11:0] b_adc_zero = 12'h000;
    logic [7:0]  b_zero8    = 8'h00;
    logic [31:0] b_zero32   = 32'h0;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_old [25] = '{8'hCA, 8'hFE, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hA5,
                                 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                                 8'hFF, 8'hFE, 8'h7F, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h01};
    logic [7:0] exp_new [25] = '{8'hCA, 8'hFE, 8'h55, 8'h66, 8'h01, 8'h23, 8'h45, 8'h67, 8'h3C,
                                 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88,
                                 8'h12, 8'h34, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h7F, 8'h00};

    debug_uart_serializer #(.W(16), .DIV(12)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_o(tx_a),
        .adc0(adc0), .adc1(adc1), .adc2(adc2), .adc3(adc3),
        .eeprom_mfg(mfg), .eeprom_dev(dev), .eeprom_serial(serial), .jack(jack),
        .touch0(touch[0]), .touch1(touch[1]), .touch2(touch[2]), .touch3(touch[3]),
        .touch4(touch[4]), .touch5(touch[5]), .touch6(touch[6]), .touch7(touch[7])
    );

    debug_uart_serializer #(.W(12), .DIV(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_o(tx_b),
        .adc0(b_adc0), .adc1(b_adc_zero), .adc2(b_adc_zero), .adc3(b_adc_zero),
        .eeprom_mfg(b_zero8), .eeprom_dev(b_zero8), .eeprom_serial(b_zero32), .jack(b_zero8),
        .touch0(b_zero8), .touch1(b_zero8), .touch2(b_zero8), .touch3(b_zero8),
        .touch4(b_zero8), .touch5(b_zero8), .touch6(b_zero8), .touch7(b_zero8)
    );

    task automatic set_old();
        mfg = 8'h12; dev = 8'h34; serial = 32'hDEADBEEF; jack = 8'hA5;
        for (int i = 0; i < 8; i++) touch[i] = 8'(i + 1);
        adc0 = 16'hFFFE; adc1 = 16'h7FFF; adc2 = 16'h8000; adc3 = 16'h0001;
    endtask

    task automatic set_new();
        mfg = 8'h55; dev = 8'h66; serial = 32'h01234567; jack = 8'h3C;
        for (int i = 0; i < 8; i++) touch[i] = 8'(8'h81 + i);
        adc0 = 16'h1234; adc1 = 16'hFFFF; adc2 = 16'h0100; adc3 = 16'h7F00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Decode one 8N1 byte; ok=0 on timeout or framing error. n_idle counts high polls before start.
    task automatic recv(input bit sel, output logic [7:0] b, output bit ok,
                        output int t_start, output int n_idle);
        int div;
        bit seen;
        div = sel ? 4 : 12;
        ok = 1'b0; b = 8'h00; t_start = 0; n_idle = 0; seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((sel ? tx_b : tx_a) === 1'b0) begin
                seen = 1'b1;
                break;
            end
            n_idle++;
        end
        if (!seen) return;
        t_start = cyc;
        repeat (div / 2) @(negedge clk);
        if ((sel ? tx_b : tx_a) !== 1'b0) return;
        for (int k = 0; k < 8; k++) begin
            repeat (div) @(negedge clk);
            b[k] = sel ? tx_b : tx_a;
        end
        repeat (div) @(negedge clk);
        ok = ((sel ? tx_b : tx_a) === 1'b1);
    endtask

    task automatic test_reset();
        bit idle_ok;
        int zeros, ones;
        rst_n = 1'b0;
        idle_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || tx_b !== 1'b1) idle_ok = 1'b0;
        end
        n_total++;
        if (!idle_ok) begin
            n_bad++;
            $display("FAIL reset_idle: tx_a=%b tx_b=%b required 1", tx_a, tx_b);
        end
        rst_n = 1'b1;
        #1;
        n_total++;
        if (tx_a !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_first_edge: tx=%b required 1", tx_a);
        end
        @(negedge clk);
        n_total++;
        if (tx_a !== 1'b0) begin
            n_bad++;
            $display("FAIL first_edge_start: tx=%b required 0", tx_a);
        end
        // start bit plus data bit 0 of 0xCA are both low, then bit 1 is high for one bit time
        zeros = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b0) break;
            zeros++;
        end
        n_total++;
        if (zeros != 24) begin
            n_bad++;
            $display("FAIL start_width: low run=%0d required 24", zeros);
        end
        ones = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1) break;
            ones++;
        end
        n_total++;
        if (ones != 12) begin
            n_bad++;
            $display("FAIL bit_width: high run=%0d required 12", ones);
        end
    endtask

    task automatic test_frame_fields();
        logic [7:0] b;
        bit ok;
        int t, n;
        set_old();
        do_reset();
        for (int i = 0; i < 25; i++) begin
            recv(1'b0, b, ok, t, n);
            n_total++;
            if (!ok || b !== exp_old[i]) begin
                n_bad++;
                $display("FAIL frame_byte%0d: got=%h ok=%0d required %h", i, b, ok, exp_old[i]);
            end
        end
    endtask

    task automatic test_snapshot_gap();
        logic [7:0] b;
        bit ok;
        int t, n, t0;
        set_old();
        do_reset();
        t0 = 0;
        for (int i = 0; i < 25; i++) begin
            if (i == 10) set_new();
            recv(1'b0, b, ok, t, n);
            if (i == 0) t0 = t;
            n_total++;
            if (!ok || b !== exp_old[i]) begin
                n_bad++;
                $display("FAIL snap_old_byte%0d: got=%h ok=%0d required %h", i, b, ok, exp_old[i]);
            end
        end
        recv(1'b0, b, ok, t, n);
        n_total++;
        if (n != 125) begin
            n_bad++;
            $display("FAIL gap_idle: high polls=%0d required 125", n);
        end
        n_total++;
        if (t - t0 != 3120) begin
            n_bad++;
            $display("FAIL frame_period: got=%0d required 3120", t - t0);
        end
        n_total++;
        if (!ok || b !== 8'hCA) begin
            n_bad++;
            $display("FAIL frame1_sync: got=%h ok=%0d required ca", b, ok);
        end
        for (int i = 1; i < 25; i++) begin
            recv(1'b0, b, ok, t, n);
            n_total++;
            if (!ok || b !== exp_new[i]) begin
                n_bad++;
                $display("FAIL snap_new_byte%0d: got=%h ok=%0d required %h", i, b, ok, exp_new[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        bit ok;
        int t, n;
        do_reset();
        for (int i = 0; i < 12; i++) recv(1'b0, b, ok, t, n);
        // mid stop of byte 11 + 30 cycles lands in data bit 1 of byte 12 (touch3=0x84, low)
        repeat (30) @(negedge clk);
        n_total++;
        if (tx_a !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_frame_low: tx=%b required 0", tx_a);
        end
        rst_n = 1'b0;
        #1;
        n_total++;
        if (tx_a !== 1'b1) begin
            n_bad++;
            $display("FAIL async_reset_tx: tx=%b required 1", tx_a);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        recv(1'b0, b, ok, t, n);
        n_total++;
        if (!ok || b !== 8'hCA) begin
            n_bad++;
            $display("FAIL restart_sync0: got=%h ok=%0d required ca", b, ok);
        end
        recv(1'b0, b, ok, t, n);
        n_total++;
        if (!ok || b !== 8'hFE) begin
            n_bad++;
            $display("FAIL restart_sync1: got=%h ok=%0d required fe", b, ok);
        end
    endtask

    task automatic test_div4_w12();
        logic [7:0] b;
        bit ok;
        int t, n, t0;
        b_adc0 = 12'h800;
        do_reset();
        recv(1'b1, b, ok, t0, n);
        n_total++;
        if (!ok || b !== 8'hCA) begin
            n_bad++;
            $display("FAIL div4_sync0: got=%h ok=%0d required ca", b, ok);
        end
        recv(1'b1, b, ok, t, n);
        n_total++;
        if (t - t0 != 40) begin
            n_bad++;
            $display("FAIL div4_byte_time: got=%0d required 40", t - t0);
        end
        for (int i = 2; i < 17; i++) recv(1'b1, b, ok, t, n);
        recv(1'b1, b, ok, t, n);
        n_total++;
        if (!ok || b !== 8'hF8) begin
            n_bad++;
            $display("FAIL div4_adc0_hi: got=%h ok=%0d required f8", b, ok);
        end
        recv(1'b1, b, ok, t, n);
        n_total++;
        if (!ok || b !== 8'h00) begin
            n_bad++;
            $display("FAIL div4_adc0_lo: got=%h ok=%0d required 00", b, ok);
        end
    endtask

    initial begin
        set_old();
        b_adc0 = 12'h800;
        test_reset();
        test_frame_fields();
        test_snapshot_gap();
        test_reset_mid_frame();
        test_div4_w12();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
